// File: rtl/i2c_reg_sequencer.sv
// Register-level transaction controller in front of I2C_master: turns one register read/write
// request into the enable/busy handshake the byte-level master expects, and reports the result.
module i2c_reg_sequencer #(
  parameter int MAX_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_req_ready,
  input  logic [6:0]  i_dev_addr,
  input  logic [7:0]  i_reg_addr,
  input  logic        i_rd_nwr,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_done,
  output logic        o_error,
  output logic [1:0]  o_err_code,
  output logic        o_m_enable,
  output logic [6:0]  o_m_slave_addr,
  output logic        o_m_rw,
  output logic [7:0]  o_m_wr_byte,
  input  logic        i_m_busy,
  input  logic [7:0]  i_m_rd_byte,
  input  logic        i_m_ack_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t        state_reg;
  logic          busy_q;
  logic [2:0]    k_reg;
  logic [2:0]    len_reg;
  logic          rd_reg;
  logic [31:0]   wr_data_reg;
  logic          ack_seen_reg;
  logic [TW-1:0] to_cnt_reg;

  logic       rise;
  logic       fall;
  logic [2:0] k_next;
  logic [1:0] byte_idx;
  logic       last_rise;
  logic       bad_len;
  logic       timeout;

  assign rise      = !busy_q && i_m_busy;
  assign fall      = busy_q && !i_m_busy;
  assign k_next    = k_reg + 3'd1;
  // Byte k of a big-endian payload sits (len-k) bytes above the LSB.
  assign byte_idx  = 2'(len_reg - k_next);
  assign last_rise = rise && (k_next == len_reg + 3'd1);
  assign bad_len   = (i_len == 3'd0) || (i_len > 3'(MAX_BYTES));
  assign timeout   = (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      busy_q         <= 1'b0;
      k_reg          <= 3'd0;
      len_reg        <= 3'd0;
      rd_reg         <= 1'b0;
      wr_data_reg    <= 32'd0;
      ack_seen_reg   <= 1'b0;
      to_cnt_reg     <= '0;
      o_req_ready    <= 1'b1;
      o_rd_data      <= 32'd0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_err_code     <= 2'b00;
      o_m_enable     <= 1'b0;
      o_m_slave_addr <= 7'd0;
      o_m_rw         <= 1'b0;
      o_m_wr_byte    <= 8'd0;
    end else begin
      busy_q <= i_m_busy;
      o_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_req) begin
            o_req_ready    <= 1'b0;
            len_reg        <= i_len;
            rd_reg         <= i_rd_nwr;
            wr_data_reg    <= i_wr_data;
            k_reg          <= 3'd0;
            ack_seen_reg   <= 1'b0;
            to_cnt_reg     <= '0;
            o_m_slave_addr <= i_dev_addr;
            if (bad_len) begin
              o_done     <= 1'b1;
              o_error    <= 1'b1;
              o_err_code <= 2'b11;
              state_reg  <= DONE;
            end else begin
              o_m_rw      <= 1'b0;
              o_m_wr_byte <= i_reg_addr;
              o_m_enable  <= 1'b1;
              o_error     <= 1'b0;
              o_err_code  <= 2'b00;
              if (i_rd_nwr)
                o_rd_data <= 32'd0;
              state_reg   <= RUN;
            end
          end
        end
        RUN, FINISH: begin
          to_cnt_reg <= (rise || fall) ? '0 : to_cnt_reg + TW'(1);
          // A timeout reports 10 even if a NACK was also pending.
          if (timeout) begin
            o_m_enable <= 1'b0;
            o_done     <= 1'b1;
            o_error    <= 1'b1;
            o_err_code <= 2'b10;
            state_reg  <= DONE;
          end else begin
            if (rise && state_reg == RUN) begin
              k_reg <= k_next;
              if (last_rise) begin
                o_m_enable <= 1'b0;
                state_reg  <= FINISH;
              end else if (rd_reg) begin
                o_m_rw <= 1'b1;
              end else begin
                o_m_wr_byte <= wr_data_reg[{byte_idx, 3'b000} +: 8];
              end
            end
            if (fall) begin
              if (i_m_ack_error)
                ack_seen_reg <= 1'b1;
              // Falls after the first read command carry received bytes.
              if (rd_reg && k_reg >= 3'd2)
                o_rd_data <= {o_rd_data[23:0], i_m_rd_byte};
              if (state_reg == FINISH) begin
                o_done     <= 1'b1;
                o_error    <= ack_seen_reg || i_m_ack_error;
                o_err_code <= (ack_seen_reg || i_m_ack_error) ? 2'b01 : 2'b00;
                state_reg  <= DONE;
              end
            end
          end
        end
        DONE: begin
          o_req_ready <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural byte-level I2C_master model that
// logs every address/data byte it would put on the bus (256 marks a repeated START).
module tb_i2c_reg_sequencer;

  localparam logic [6:0] ABSENT = 7'h3C;
  localparam int         SR     = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_ready;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic        rd_nwr;
  logic [2:0]  len;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        m_enable;
  logic [6:0]  m_slave_addr;
  logic        m_rw;
  logic [7:0]  m_wr_byte;
  logic        m_busy;
  logic [7:0]  m_rd_byte;
  logic        m_ack_error;

  int compared   = 0;
  int mismatched = 0;

  int         log_q[$];
  logic [7:0] slv_q[$];
  logic       hang;
  int         m_cnt;
  int         m_gap;
  bit         in_txn;
  logic       prev_rw;
  logic       cur_rw;
  logic [6:0] cur_addr;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.MAX_BYTES(4), .TIMEOUT_CYCLES(1000)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_req_ready(req_ready),
    .i_dev_addr(dev_addr), .i_reg_addr(reg_addr), .i_rd_nwr(rd_nwr), .i_len(len),
    .i_wr_data(wr_data), .o_rd_data(rd_data), .o_done(done), .o_error(error),
    .o_err_code(err_code), .o_m_enable(m_enable), .o_m_slave_addr(m_slave_addr),
    .o_m_rw(m_rw), .o_m_wr_byte(m_wr_byte), .i_m_busy(m_busy),
    .i_m_rd_byte(m_rd_byte), .i_m_ack_error(m_ack_error)
  );

  // Master model: latch a command when enabled, stay busy for a byte time, then drop busy.
  initial begin
    m_busy = 0; m_rd_byte = 0; m_ack_error = 0; hang = 0;
    m_cnt = 0; m_gap = 0; in_txn = 0; prev_rw = 0; cur_rw = 0; cur_addr = 0;
    forever begin
      @(posedge clk); #1;
      if (m_busy) begin
        if (m_cnt > 0) m_cnt--;
        else if (!hang) begin
          m_busy = 0;
          m_ack_error = (cur_addr == ABSENT);
          if (cur_rw) m_rd_byte = (slv_q.size() > 0) ? slv_q.pop_front() : 8'hFF;
          if (m_ack_error) in_txn = 0;
          m_gap = 3;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_enable) begin
        if (!in_txn || m_rw != prev_rw) begin
          if (in_txn) log_q.push_back(SR);
          log_q.push_back(int'({m_slave_addr, m_rw}));
        end
        if (!m_rw) log_q.push_back(int'(m_wr_byte));
        in_txn = 1; prev_rw = m_rw; cur_rw = m_rw; cur_addr = m_slave_addr;
        m_ack_error = 0; m_busy = 1; m_cnt = 8;
      end else begin
        in_txn = 0;
      end
    end
  end

  task automatic do_request(input logic [6:0] d, input logic [7:0] r, input logic rd,
                            input logic [2:0] l, input logic [31:0] w);
    @(posedge clk); #1;
    dev_addr = d; reg_addr = r; rd_nwr = rd; len = l; wr_data = w; req = 1;
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic wait_done(input int budget, output bit got, output int cyc,
                           output logic err, output logic [1:0] code);
    got = 0; cyc = 0; err = 0; code = 0;
    while (!got && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin got = 1; err = error; code = err_code; end
    end
  endtask

  task automatic wait_master_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!m_busy && m_gap == 0 && !in_txn) break;
    end
  endtask

  task automatic test_reset();
    rst = 1; req = 0; dev_addr = 0; reg_addr = 0; rd_nwr = 0; len = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    compared++;
    if ({done, error, err_code} !== 4'b0000) begin mismatched++; $display("FAIL reset_status: got %b expected 0000", {done, error, err_code}); end
    compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    compared++;
    if ({m_enable, m_slave_addr, m_rw, m_wr_byte} !== 17'd0) begin mismatched++; $display("FAIL reset_master_if: got %h expected 0", {m_enable, m_slave_addr, m_rw, m_wr_byte}); end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (req_ready !== 1'b1 || m_enable !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle: ready=%b enable=%b expected 1/0", req_ready, m_enable); end
    $display("reset: done");
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    int got_v;
    compared++;
    if (log_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_len: got %0d bytes expected %0d", name, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got_v = (i < log_q.size()) ? log_q[i] : -1;
      compared++;
      if (got_v != exp_q[i]) begin mismatched++; $display("FAIL %s[%0d]: got %0h expected %0h", name, i, got_v, exp_q[i]); end
    end
  endtask

  task automatic test_write(input logic [6:0] d, input logic [7:0] r, input logic [2:0] l,
                            input logic [31:0] w, input int exp_q[$], input string name);
    bit got; int cyc; logic err; logic [1:0] code;
    log_q.delete();
    do_request(d, r, 1'b0, l, w);
    compared++;
    if (req_ready !== 1'b0) begin mismatched++; $display("FAIL %s_ready_low: got %b expected 0", name, req_ready); end
    wait_done(500, got, cyc, err, code);
    compared++;
    if (!got) begin mismatched++; $display("FAIL %s_done: got no o_done expected pulse within 500 cycles", name); end
    compared++;
    if ({err, code} !== 3'b000) begin mismatched++; $display("FAIL %s_err: got %b/%b expected 0/00", name, err, code); end
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin mismatched++; $display("FAIL %s_after: done=%b ready=%b expected 0/1", name, done, req_ready); end
    wait_master_idle();
    check_log(name, exp_q);
    $display("%s: dev=%h reg=%h len=%0d data=%h bytes=%0d err=%b", name, d, r, l, w, log_q.size(), code);
  endtask

  task automatic test_read();
    bit got; int cyc; logic err; logic [1:0] code;
    log_q.delete();
    slv_q = '{8'h11, 8'h22, 8'h33};
    do_request(7'h50, 8'h20, 1'b1, 3'd3, 32'd0);
    wait_done(500, got, cyc, err, code);
    compared++;
    if (!got) begin mismatched++; $display("FAIL read_done: got no o_done expected pulse within 500 cycles"); end
    compared++;
    if ({err, code} !== 3'b000) begin mismatched++; $display("FAIL read_err: got %b/%b expected 0/00", err, code); end
    compared++;
    if (rd_data !== 32'h0011_2233) begin mismatched++; $display("FAIL read_data: got %h expected 00112233", rd_data); end
    wait_master_idle();
    check_log("read_log", '{32'hA0, 32'h20, SR, 32'hA1});
    $display("read: dev=50 reg=20 len=3 rd_data=%h err=%b", rd_data, code);
  endtask

  task automatic test_nack();
    bit got; int cyc; logic err; logic [1:0] code;
    do_request(ABSENT, 8'h05, 1'b0, 3'd1, 32'h77);
    wait_done(500, got, cyc, err, code);
    compared++;
    if (!got) begin mismatched++; $display("FAIL nack_done: got no o_done expected pulse within 500 cycles"); end
    compared++;
    if ({err, code} !== 3'b101) begin mismatched++; $display("FAIL nack_err: got %b/%b expected 1/01", err, code); end
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b1 || m_enable !== 1'b0) begin mismatched++; $display("FAIL nack_idle: ready=%b enable=%b expected 1/0", req_ready, m_enable); end
    compared++;
    if (rd_data !== 32'h0011_2233) begin mismatched++; $display("FAIL nack_rd_hold: got %h expected 00112233", rd_data); end
    wait_master_idle();
    $display("nack: dev=3c err=%b code=%b", err, code);
  endtask

  task automatic test_timeout();
    bit got; int cyc; logic err; logic [1:0] code;
    hang = 1;
    do_request(7'h50, 8'h01, 1'b0, 3'd1, 32'h99);
    wait_done(1200, got, cyc, err, code);
    compared++;
    if (!got) begin mismatched++; $display("FAIL timeout_done: got no o_done expected pulse within 1200 cycles"); end
    compared++;
    if ({err, code} !== 3'b110) begin mismatched++; $display("FAIL timeout_err: got %b/%b expected 1/10", err, code); end
    compared++;
    if (cyc < 990 || cyc > 1030) begin mismatched++; $display("FAIL timeout_latency: got %0d cycles expected 990..1030", cyc); end
    compared++;
    if (m_enable !== 1'b0) begin mismatched++; $display("FAIL timeout_enable: got %b expected 0", m_enable); end
    hang = 0;
    wait_master_idle();
    $display("timeout: cycles=%0d code=%b", cyc, code);
  endtask

  task automatic test_bad_len(input logic [2:0] l);
    log_q.delete();
    do_request(7'h50, 8'h10, 1'b0, l, 32'h1234_5678);
    compared++;
    if ({done, error, err_code} !== 4'b1111) begin mismatched++; $display("FAIL badlen%0d_status: got %b expected 1111", l, {done, error, err_code}); end
    compared++;
    if (m_enable !== 1'b0) begin mismatched++; $display("FAIL badlen%0d_enable: got %b expected 0", l, m_enable); end
    repeat (20) begin
      @(posedge clk); #1;
    end
    compared++;
    if (log_q.size() != 0 || req_ready !== 1'b1) begin mismatched++; $display("FAIL badlen%0d_quiet: bytes=%0d ready=%b expected 0/1", l, log_q.size(), req_ready); end
    $display("bad_len: len=%0d code=11 expected, bus bytes=%0d", l, log_q.size());
  endtask

  task automatic test_reset_mid_read();
    slv_q = '{8'hDE, 8'hAD};
    do_request(7'h50, 8'h40, 1'b1, 3'd2, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    rst = 1;
    #1;
    compared++;
    if (m_enable !== 1'b0) begin mismatched++; $display("FAIL midrst_enable: got %b expected 0", m_enable); end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin mismatched++; $display("FAIL midrst_ready: ready=%b done=%b expected 1/0", req_ready, done); end
    wait_master_idle();
    slv_q.delete();
    $display("reset_mid_read: enable=%b ready=%b", m_enable, req_ready);
  endtask

  initial begin
    req = 0; rst = 1;
    test_reset();
    test_write(7'h50, 8'h10, 3'd2, 32'h0000_A55A, '{32'hA0, 32'h10, 32'hA5, 32'h5A}, "write");
    test_read();
    test_nack();
    test_timeout();
    test_bad_len(3'd0);
    test_bad_len(3'd5);
    test_reset_mid_read();
    test_write(7'h51, 8'h33, 3'd4, 32'h0102_0304,
               '{32'hA2, 32'h33, 32'h01, 32'h02, 32'h03, 32'h04}, "back_to_back");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
